// File: rtl/sid_filter_pkg.sv
// Shared constants and coefficient helpers for the time-multiplexed SID state-variable filter.
package sid_filter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_M_HP   = 3'd1;
    localparam logic [2:0] ST_M_BP   = 3'd2;
    localparam logic [2:0] ST_M_Q    = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;
    localparam logic [2:0] ST_MIX    = 3'd5;

    localparam logic [11:0] FC_KNEE    = 12'hA37;
    localparam logic [17:0] W0_BASE    = 18'd797;
    localparam logic [17:0] W0_SLOPE   = 18'd40;
    localparam logic [17:0] W0_MAX     = 18'd105397;
    localparam int          MIX_OFFSET = 1024;

    // Linear cutoff ramp that flattens out above the knee
    function automatic logic signed [17:0] w0_calc(input logic [11:0] fc);
        logic [17:0] w0;
        if (fc < FC_KNEE)
            w0 = {6'd0, fc} * W0_SLOPE + W0_BASE;
        else
            w0 = W0_MAX;
        return signed'(w0);
    endfunction

    function automatic logic signed [17:0] q_lut(input logic [3:0] res);
        logic signed [17:0] q;
        case (res)
            4'd0:    q = 18'sd1448;
            4'd1:    q = 18'sd1323;
            4'd2:    q = 18'sd1218;
            4'd3:    q = 18'sd1128;
            4'd4:    q = 18'sd1051;
            4'd5:    q = 18'sd984;
            4'd6:    q = 18'sd925;
            4'd7:    q = 18'sd872;
            4'd8:    q = 18'sd825;
            4'd9:    q = 18'sd783;
            4'd10:   q = 18'sd745;
            4'd11:   q = 18'sd710;
            4'd12:   q = 18'sd679;
            4'd13:   q = 18'sd650;
            4'd14:   q = 18'sd624;
            default: q = 18'sd599;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/sid_filter_seq_if.sv
// Sample-side bus between the voice mixer, the filter sequencer and the volume stage.
interface sid_filter_seq_if;
    logic        sample_stb;
    logic [11:0] in;
    logic [11:0] fc;
    logic [3:0]  resonance;
    logic        high_pass;
    logic        band_pass;
    logic        low_pass;
    logic        busy;
    logic [11:0] out;
    logic        out_valid;
    logic        overrun;

    modport master (
        output sample_stb, in, fc, resonance, high_pass, band_pass, low_pass,
        input  busy, out, out_valid, overrun
    );

    modport slave (
        input  sample_stb, in, fc, resonance, high_pass, band_pass, low_pass,
        output busy, out, out_valid, overrun
    );
endinterface

// File: rtl/sid_filter_mul.sv
// Registered signed state x coefficient multiply followed by a selectable arithmetic shift.
module sid_filter_mul #(
    parameter int STATE_W  = 32,
    parameter int COEF_W   = 18,
    parameter int W0_SHIFT = 20,
    parameter int Q_SHIFT  = 10
) (
    input  logic                      clk,
    input  logic signed [STATE_W-1:0] a,
    input  logic signed [COEF_W-1:0]  b,
    input  logic                      shift_q,
    output logic signed [STATE_W-1:0] p
);

    logic signed [STATE_W+COEF_W-1:0] prod;

    assign prod = a * b;

    // Full-width product is shifted first, then truncated back to state width
    always_ff @(posedge clk) begin
        p <= STATE_W'(shift_q ? (prod >>> Q_SHIFT) : (prod >>> W0_SHIFT));
    end

endmodule

// File: rtl/sid_filter_seq.sv
// SID state-variable filter: one shared multiplier stepped through HP/BP/Q products per sample,
// atomic integrator commit, then output mix with offset and clamp.
module sid_filter_seq
    import sid_filter_pkg::*;
#(
    parameter int STATE_W  = 32,
    parameter int COEF_W   = 18,
    parameter int W0_SHIFT = 20,
    parameter int Q_SHIFT  = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    sid_filter_seq_if.slave bus
);

    logic [2:0]                state;
    logic signed [STATE_W-1:0] vhp, vbp, vlp;
    logic signed [STATE_W-1:0] p_hp, p_bp, mul_p;
    logic signed [STATE_W-1:0] mul_a, in_ext;
    logic signed [COEF_W-1:0]  mul_b, w0_l, q_l;
    logic [11:0]               in_l;
    logic [2:0]                mode_l;
    logic signed [STATE_W+1:0] mix_sum;

    function automatic logic [11:0] clamp_out(input logic signed [STATE_W+1:0] s);
        if (s[STATE_W+1])
            return 12'd0;
        else if (s > (STATE_W+2)'(4095))
            return 12'hFFF;
        else
            return s[11:0];
    endfunction

    assign in_ext   = {{(STATE_W-12){1'b0}}, in_l};
    assign bus.busy = (state != ST_IDLE);

    always_comb begin
        mul_a = vhp;
        mul_b = w0_l;
        case (state)
            ST_M_BP: mul_a = vbp;
            ST_M_Q: begin
                mul_a = vbp;
                mul_b = q_l;
            end
            default: ;
        endcase
    end

    sid_filter_mul #(
        .STATE_W (STATE_W),
        .COEF_W  (COEF_W),
        .W0_SHIFT(W0_SHIFT),
        .Q_SHIFT (Q_SHIFT)
    ) u_mul (
        .clk    (clk),
        .a      (mul_a),
        .b      (mul_b),
        .shift_q(state == ST_M_Q),
        .p      (mul_p)
    );

    // Operands are frozen at acceptance; product from the previous state is parked here
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.sample_stb) begin
            in_l   <= bus.in;
            w0_l   <= COEF_W'(w0_calc(bus.fc));
            q_l    <= COEF_W'(q_lut(bus.resonance));
            mode_l <= {bus.high_pass, bus.band_pass, bus.low_pass};
        end
        if (state == ST_M_BP) p_hp <= mul_p;
        if (state == ST_M_Q)  p_bp <= mul_p;
    end

    always_comb begin
        mix_sum = (STATE_W+2)'(MIX_OFFSET);
        if (mode_l[2]) mix_sum = mix_sum + (STATE_W+2)'(vhp);
        if (mode_l[1]) mix_sum = mix_sum + (STATE_W+2)'(vbp);
        if (mode_l[0]) mix_sum = mix_sum + (STATE_W+2)'(vlp);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            vhp           <= '0;
            vbp           <= '0;
            vlp           <= '0;
            bus.out       <= 12'd0;
            bus.out_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.overrun   <= bus.sample_stb && (state != ST_IDLE);
            case (state)
                ST_IDLE:   if (bus.sample_stb) state <= ST_M_HP;
                ST_M_HP:   state <= ST_M_BP;
                ST_M_BP:   state <= ST_M_Q;
                ST_M_Q:    state <= ST_COMMIT;
                // mul_p holds the Q product here; every update reads pre-commit state
                ST_COMMIT: begin
                    vbp   <= vbp - p_hp;
                    vlp   <= vlp - p_bp;
                    vhp   <= mul_p - vlp + in_ext;
                    state <= ST_MIX;
                end
                ST_MIX: begin
                    bus.out       <= (mode_l == 3'b000) ? 12'd0 : clamp_out(mix_sum);
                    bus.out_valid <= 1'b1;
                    state         <= ST_IDLE;
                end
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
